prime_reduce_arb: RTL and testbench

PRIME_REDUCE_ARB -- requirements
Module: prime_reduce_arb

---
 rtl/prime_reduce_arb.sv | 167 ++++++++++++++++
 tb/tb_prime_reduce_arb.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prime_reduce_arb.sv
// Two requesters share one mod-7681 reducer; results return through a 2-entry in-order FIFO.
// Define PRIME_REDUCE_ARB_RR_EN for round-robin arbitration (default: fixed priority to port 0).

module prime_reduce (
    input  logic        clk,
    input  logic [26:0] din,
    output logic [12:0] out
);
    localparam int unsigned MODQ = 7681;

    logic [26:0] din_q;
    logic [23:0] f0;
    logic [23:0] f1;
    logic [23:0] f2;
    logic [23:0] f3;
    logic [23:0] r;

    always_ff @(posedge clk) begin
        din_q <= din;
    end

    // 2^13 == 2^9 - 1 (mod 7681): each fold maps hi*2^13 + lo to hi*511 + lo
    function automatic logic [23:0] fold(input logic [23:0] v);
        logic [10:0] hi;
        hi = v[23:13];
        return (24'(hi) << 9) - 24'(hi) + 24'(v[12:0]);
    endfunction

    always_comb begin
        f0 = (24'(din_q[26:13]) << 9) - 24'(din_q[26:13]) + 24'(din_q[12:0]);
        f1 = fold(f0);
        f2 = fold(f1);
        f3 = fold(f2);
        r  = (f3 >= 24'(MODQ)) ? (f3 - 24'(MODQ)) : f3;
        out = 13'(r);
    end
endmodule

module prime_reduce_arb #(
    parameter  int unsigned TAG_W  = 4,
    localparam int unsigned DATA_W = 27,
    localparam int unsigned RES_W  = 13
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [DATA_W-1:0]  req0_data,
    input  logic [TAG_W-1:0]   req0_tag,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [DATA_W-1:0]  req1_data,
    input  logic [TAG_W-1:0]   req1_tag,
    output logic               rsp0_valid,
    input  logic               rsp0_ready,
    output logic [RES_W-1:0]   rsp0_data,
    output logic [TAG_W-1:0]   rsp0_tag,
    output logic               rsp1_valid,
    input  logic               rsp1_ready,
    output logic [RES_W-1:0]   rsp1_data,
    output logic [TAG_W-1:0]   rsp1_tag,
    output logic               busy
);
    localparam int unsigned DEPTH = 2;

    typedef struct packed {
        logic             owner;
        logic [TAG_W-1:0] tag;
        logic [RES_W-1:0] data;
    } entry_t;

    logic              live;
    logic              s1_v;
    logic              s1_owner;
    logic [TAG_W-1:0]  s1_tag;
    entry_t            mem [DEPTH];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        fifo_count;
    entry_t            head;
    logic              fifo_nempty;
    logic              pop;
    logic [2:0]        occ;
    logic              credit;
    logic              win0;
    logic              win1;
    logic              iss0;
    logic              iss1;
    logic [DATA_W-1:0] red_in;
    logic [RES_W-1:0]  red_out;

    prime_reduce u_reduce (
        .clk (clk),
        .din (red_in),
        .out (red_out)
    );

    // Held low by reset so no grant is offered until the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) live <= 1'b0;
        else        live <= 1'b1;
    end

    assign head        = mem[rd_ptr];
    assign fifo_nempty = (fifo_count != 2'd0);
    assign pop         = fifo_nempty & (head.owner ? rsp1_ready : rsp0_ready);
    assign occ         = 3'(fifo_count) + 3'(s1_v) - 3'(pop);
    assign credit      = live & (occ < 3'(DEPTH));

`ifdef PRIME_REDUCE_ARB_RR_EN
    logic rr_pri;

    // rr_pri names the port that wins the next conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    rr_pri <= 1'b0;
        else if (iss0) rr_pri <= 1'b1;
        else if (iss1) rr_pri <= 1'b0;
    end

    assign win0 = ~req1_valid | ~rr_pri;
    assign win1 = ~req0_valid | rr_pri;
`else
    assign win0 = 1'b1;
    assign win1 = ~req0_valid;
`endif

    assign req0_ready = credit & win0;
    assign req1_ready = credit & win1;
    assign iss0       = req0_valid & req0_ready;
    assign iss1       = req1_valid & req1_ready;
    assign red_in     = iss1 ? req1_data : req0_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) s1_v <= 1'b0;
        else        s1_v <= iss0 | iss1;
    end

    always_ff @(posedge clk) begin
        s1_owner <= iss1;
        s1_tag   <= iss1 ? req1_tag : req0_tag;
    end

    // S1 never stalls: the credit check guarantees a free FIFO slot for it.
    always_ff @(posedge clk) begin
        if (s1_v) mem[wr_ptr] <= '{owner: s1_owner, tag: s1_tag, data: red_out};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
        end else begin
            wr_ptr     <= wr_ptr ^ s1_v;
            rd_ptr     <= rd_ptr ^ pop;
            fifo_count <= fifo_count + 2'(s1_v) - 2'(pop);
        end
    end

    assign rsp0_valid = fifo_nempty & ~head.owner;
    assign rsp1_valid = fifo_nempty & head.owner;
    assign rsp0_data  = head.data;
    assign rsp1_data  = head.data;
    assign rsp0_tag   = head.tag;
    assign rsp1_tag   = head.tag;
    assign busy       = s1_v | fifo_nempty;
endmodule

// File: tb/tb_prime_reduce_arb.sv
// Scoreboard bench for prime_reduce_arb; honours PRIME_REDUCE_ARB_RR_EN for arbitration expectations.

module tb_prime_reduce_arb;
    localparam int unsigned TAG_W = 4;
    localparam int unsigned MODQ  = 7681;

    logic              clk;
    logic              rst_n;
    logic              req0_valid, req1_valid, req0_ready, req1_ready;
    logic [26:0]       req0_data, req1_data;
    logic [TAG_W-1:0]  req0_tag, req1_tag, rsp0_tag, rsp1_tag;
    logic              rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [12:0]       rsp0_data, rsp1_data;
    logic              busy;

    typedef struct {
        logic [12:0]      data;
        logic [TAG_W-1:0] tag;
    } exp_t;

    int          n_checks;
    int          n_errors;
    int          hs_cnt;
    exp_t        exp_q0[$];
    exp_t        exp_q1[$];
    int          grant_log[$];
    logic [12:0] got0_log[$];

    logic [26:0] bvals [6] = '{27'd0, 27'd7680, 27'd7681, 27'd15362, 27'd23043, 27'd134217727};
    logic [12:0] bexp  [6] = '{13'd0, 13'd7680, 13'd0, 13'd0, 13'd0, 13'd7614};
`ifdef PRIME_REDUCE_ARB_RR_EN
    int          gexp  [4] = '{0, 1, 0, 1};
`else
    int          gexp  [4] = '{0, 0, 0, 0};
`endif

    prime_reduce_arb #(.TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req0_tag   (req0_tag),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .req1_tag   (req1_tag),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_data  (rsp0_data),
        .rsp0_tag   (rsp0_tag),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_data  (rsp1_data),
        .rsp1_tag   (rsp1_tag),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic exp_t mk(input logic [26:0] d, input logic [TAG_W-1:0] t);
        exp_t e;
        e.data = 13'(32'(d) % MODQ);
        e.tag  = t;
        return e;
    endfunction

    // Observe handshakes mid-cycle: requests push expectations, responses pop and compare.
    always @(negedge clk) begin
        if (rst_n) begin
            exp_t e;
            if (req0_valid && req0_ready) begin
                exp_q0.push_back(mk(req0_data, req0_tag));
                grant_log.push_back(0);
                hs_cnt++;
            end
            if (req1_valid && req1_ready) begin
                exp_q1.push_back(mk(req1_data, req1_tag));
                grant_log.push_back(1);
                hs_cnt++;
            end
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready))
                check("issue_onehot", 32'(req0_valid & req0_ready & req1_valid & req1_ready), 32'd0);
            if (rsp0_valid || rsp1_valid)
                check("rsp_onehot", 32'(rsp0_valid & rsp1_valid), 32'd0);
            if (rsp0_valid && rsp0_ready) begin
                if (exp_q0.size() == 0) check("rsp0_spurious", 32'd1, 32'd0);
                else begin
                    e = exp_q0.pop_front();
                    check("rsp0_data", 32'(rsp0_data), 32'(e.data));
                    check("rsp0_tag", 32'(rsp0_tag), 32'(e.tag));
                    got0_log.push_back(rsp0_data);
                end
            end
            if (rsp1_valid && rsp1_ready) begin
                if (exp_q1.size() == 0) check("rsp1_spurious", 32'd1, 32'd0);
                else begin
                    e = exp_q1.pop_front();
                    check("rsp1_data", 32'(rsp1_data), 32'(e.data));
                    check("rsp1_tag", 32'(rsp1_tag), 32'(e.tag));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q0.delete();
        exp_q1.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while ((busy || exp_q0.size() != 0 || exp_q1.size() != 0) && k < 60) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(k < 60), 32'd1);
        tick();
    endtask

    task automatic send(input int port, input logic [26:0] d, input logic [TAG_W-1:0] t);
        int k;
        bit ok;
        k  = 0;
        ok = 1'b0;
        if (port == 0) begin req0_valid = 1'b1; req0_data = d; req0_tag = t; end
        else           begin req1_valid = 1'b1; req1_data = d; req1_tag = t; end
        while (!ok && k < 50) begin
            @(negedge clk);
            ok = (port == 0) ? req0_ready : req1_ready;
            k++;
        end
        check("send_grant", 32'(ok), 32'd1);
        tick();
        if (port == 0) req0_valid = 1'b0;
        else           req1_valid = 1'b0;
    endtask

    // Single operand with cycle-exact latency checks, value expected at t+2.
    task automatic single_op(input string tag, input logic [26:0] d, input logic [TAG_W-1:0] t,
                             input logic [12:0] want);
        req0_valid = 1'b1; req0_data = d; req0_tag = t;
        @(negedge clk);
        check({tag, "_ready"}, 32'(req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        check({tag, "_t1_valid"}, 32'(rsp0_valid), 32'd0);
        check({tag, "_t1_busy"}, 32'(busy), 32'd1);
        tick();
        @(negedge clk);
        check({tag, "_t2_valid"}, 32'(rsp0_valid), 32'd1);
        check({tag, "_t2_data"}, 32'(rsp0_data), 32'(want));
        check({tag, "_t2_tag"}, 32'(rsp0_tag), 32'(t));
        check({tag, "_t2_rsp1"}, 32'(rsp1_valid), 32'd0);
        tick();
        wait_idle({tag, "_idle"});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_errors = 0; hs_cnt = 0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = '0; req1_data = '0; req0_tag = '0; req1_tag = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_req0_ready", 32'(req0_ready), 32'd0);
        check("rst_req1_ready", 32'(req1_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp0_valid | rsp1_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        single_op("single", 27'd12345, 4'd3, 13'd4664);

        // Boundary operands streamed back to back.
        got0_log.delete();
        for (int i = 0; i < 6; i++) send(0, bvals[i], TAG_W'(i));
        wait_idle("bound_idle");
        check("bound_count", 32'(got0_log.size()), 32'd6);
        if (got0_log.size() == 6)
            for (int i = 0; i < 6; i++) check($sformatf("bound_%0d", i), 32'(got0_log[i]), 32'(bexp[i]));

        // Both requesters contend for four cycles.
        do_reset();
        grant_log.delete();
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            req0_data = 27'($urandom); req0_tag = TAG_W'(c);
            req1_data = 27'($urandom); req1_tag = TAG_W'(c + 8);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle("conf_idle");
        check("conf_count", 32'(grant_log.size()), 32'd4);
        if (grant_log.size() == 4)
            for (int i = 0; i < 4; i++) check($sformatf("conf_grant%0d", i), 32'(grant_log[i]), 32'(gexp[i]));

        // Backpressure: two results buffered, then drain and resume.
        got0_log.delete();
        hs_cnt = 0;
        rsp0_ready = 1'b0;
        req0_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            req0_data = 27'($urandom); req0_tag = TAG_W'(c);
            @(negedge clk);
            check($sformatf("bp_ready%0d", c), 32'(req0_ready), 32'(c < 2));
            tick();
        end
        check("bp_hold_valid", 32'(rsp0_valid), 32'd1);
        rsp0_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            req0_data = 27'($urandom); req0_tag = TAG_W'(c + 5);
            @(negedge clk);
            check($sformatf("bp_resume%0d", c), 32'(req0_ready), 32'd1);
            tick();
        end
        req0_valid = 1'b0;
        wait_idle("bp_idle");
        check("bp_issued", 32'(hs_cnt), 32'd6);
        check("bp_returned", 32'(got0_log.size()), 32'd6);

        // Head-of-line: owner-0 head blocks a ready owner-1 entry behind it.
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b1;
        send(0, 27'($urandom), 4'd1);
        send(1, 27'($urandom), 4'd2);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("hol_rsp1_%0d", c), 32'(rsp1_valid), 32'd0);
            check($sformatf("hol_rsp0_%0d", c), 32'(rsp0_valid), 32'd1);
            tick();
        end
        rsp0_ready = 1'b1;
        @(negedge clk);
        check("hol_pop_head", 32'(rsp0_valid), 32'd1);
        tick();
        @(negedge clk);
        check("hol_rsp1_after", 32'(rsp1_valid), 32'd1);
        wait_idle("hol_idle");

        // Reset with two operands in flight discards them.
        rsp0_ready = 1'b0;
        send(0, 27'($urandom), 4'd4);
        send(0, 27'($urandom), 4'd5);
        rst_n = 1'b0;
        exp_q0.delete();
        exp_q1.delete();
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_rsp0", 32'(rsp0_valid), 32'd0);
        check("mid_rst_ready", 32'(req0_ready | req1_ready), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        rsp0_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("post_rst_quiet%0d", c), 32'(rsp0_valid | rsp1_valid), 32'd0);
            tick();
        end
        single_op("post_rst", 27'd100000, 4'd5, 13'd147);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
